// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, legality check and arbiter FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_arb_state_t;

    // True for the opcodes the ALU actually implements
    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
            default:                                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu.sv
// The existing 64-bit ALU: purely combinational, wrap-around arithmetic, no carry out.
module alu
    import alu_pkg::*;
(
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic [3:0]  op_sel,
    output logic [63:0] result,
    output logic        zero
);

    // Select the operation; unknown encodings produce zero
    always_comb begin
        result = '0;
        case (op_sel)
            ALU_AND: result = src1 & src2;
            ALU_OR:  result = src1 | src2;
            ALU_ADD: result = src1 + src2;
            ALU_SUB: result = src1 - src2;
            ALU_SLT: result = {63'd0, ($signed(src1) < $signed(src2))};
            ALU_NOR: result = ~(src1 | src2);
            default: result = '0;
        endcase
    end

    assign zero = (result == 64'd0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the pointer, with wrap.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    int unsigned slot;

    // Walk the requesters starting at the pointer and take the first active one
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        slot      = 0;
        for (int i = 0; i < N; i++) begin
            slot = (int'(ptr) + i) % N;
            if (!grant_any && req[slot]) begin
                grant[slot] = 1'b1;
                grant_idx   = IDX_W'(slot);
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters: grant, execute from latched operands, hold response.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0][63:0] req_src1,
    input  logic [NUM_REQ-1:0][63:0] req_src2,
    input  logic [NUM_REQ-1:0][3:0]  req_op,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [63:0]              resp_result,
    output logic                     resp_zero,
    output logic                     resp_err,
    output logic                     busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    alu_arb_state_t   state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic             grant_any;
    logic [63:0]      op_a;
    logic [63:0]      op_b;
    logic [3:0]       op_code;
    logic [63:0]      alu_result;
    logic             alu_zero;
    logic             op_legal;
    logic             owner_ack;
    logic [IDX_W-1:0] next_ptr;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    alu u_alu (
        .src1   (op_a),
        .src2   (op_b),
        .op_sel (op_code),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign op_legal   = is_legal_op(op_code);
    assign req_ready  = (rst_n && (state == IDLE)) ? grant : '0;
    assign resp_valid = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
    assign owner_ack  = resp_ready[owner];
    assign busy       = (state != IDLE);
    assign next_ptr   = IDX_W'((int'(owner) + 1) % NUM_REQ);

    // Transaction FSM: latch the granted request, run it through the ALU, hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_code     <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_a    <= req_src1[grant_idx];
                        op_b    <= req_src2[grant_idx];
                        op_code <= req_op[grant_idx];
                        owner   <= grant_idx;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result <= op_legal ? alu_result : 64'd0;
                    resp_zero   <= op_legal ? alu_zero : 1'b0;
                    resp_err    <= ~op_legal;
                    state       <= RESP;
                end
                RESP: begin
                    if (owner_ack) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with two requesters and hand-computed results.
module tb_alu_share_arbiter;

    localparam int NUM_REQ = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0][63:0] req_src1;
    logic [NUM_REQ-1:0][63:0] req_src2;
    logic [NUM_REQ-1:0][3:0]  req_op;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [63:0]              resp_result;
    logic                     resp_zero;
    logic                     resp_err;
    logic                     busy;

    int nChecks;
    int nFails;

    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    alu_share_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_src1    (req_src1),
        .req_src2    (req_src2),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Present a request on one port and raise its valid
    task automatic applyStimulus(input int idx, input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        req_src1[idx]  = a;
        req_src2[idx]  = b;
        req_op[idx]    = op;
        req_valid[idx] = 1'b1;
    endtask

    // Reset pulse with checks on every output while held low
    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        checkOutput({tag, "_rst_rdy"},  64'(req_ready), 64'd0);
        checkOutput({tag, "_rst_rv"},   64'(resp_valid), 64'd0);
        checkOutput({tag, "_rst_res"},  resp_result, 64'd0);
        checkOutput({tag, "_rst_flag"}, {61'd0, resp_zero, resp_err, busy}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full transaction from an IDLE negedge with resp_ready high; ends at the next IDLE negedge
    task automatic serve(input string tag, input logic [1:0] expGrant, input logic [63:0] expRes,
                         input logic expZero, input logic expErr);
        #1;
        checkOutput({tag, "_grant"}, 64'(req_ready), 64'(expGrant));
        @(negedge clk);
        req_valid = req_valid & ~expGrant;
        #1;
        checkOutput({tag, "_exec"}, {62'd0, busy, (req_ready != 0)}, {62'd0, 1'b1, 1'b0});
        @(negedge clk);
        #1;
        checkOutput({tag, "_rv"},   64'(resp_valid), 64'(expGrant));
        checkOutput({tag, "_res"},  resp_result, expRes);
        checkOutput({tag, "_flag"}, {62'd0, resp_zero, resp_err}, {62'd0, expZero, expErr});
        @(negedge clk);
    endtask

    initial begin
        nChecks    = 0;
        nFails     = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_src1   = '0;
        req_src2   = '0;
        req_op     = '0;
        resp_ready = 2'b11;
        @(negedge clk);

        // Simple AND with immediate acceptance
        doReset("t1");
        applyStimulus(0, 64'hFFFF_FFFF, 64'hFF, 4'd0);
        serve("t1", 2'b01, 64'hFF, 1'b0, 1'b0);
        #1;
        checkOutput("t1_idle_rv", 64'(resp_valid), 64'd0);

        // Concurrent requests out of reset, round-robin order
        doReset("t2");
        applyStimulus(0, 64'd64, 64'd100, 4'd2);
        applyStimulus(1, 64'd64, 64'd64, 4'd6);
        serve("t2a", 2'b01, 64'd164, 1'b0, 1'b0);
        serve("t2b", 2'b10, 64'd0, 1'b1, 1'b0);
        applyStimulus(0, 64'hF0F0, 64'hFF00, 4'd0);
        applyStimulus(1, 64'd10, 64'd3, 4'd6);
        serve("t2c", 2'b01, 64'hF000, 1'b0, 1'b0);
        serve("t2d", 2'b10, 64'd7, 1'b0, 1'b0);

        // Back-pressure on the response while another requester waits
        resp_ready = 2'b00;
        applyStimulus(0, 64'd4, 64'd5, 4'd7);
        #1;
        checkOutput("t3_grant", 64'(req_ready), 64'(2'b01));
        @(negedge clk);
        req_valid[0] = 1'b0;
        applyStimulus(1, 64'd3, 64'd4, 4'd1);
        #1;
        checkOutput("t3_exec_rdy", 64'(req_ready), 64'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("t3_hold_rv",  64'(resp_valid), 64'(2'b01));
            checkOutput("t3_hold_res", resp_result, 64'd1);
            checkOutput("t3_hold_rdy", 64'(req_ready), 64'd0);
            resp_ready = (i % 2 == 1) ? 2'b10 : 2'b00;
            @(negedge clk);
        end
        resp_ready = 2'b01;
        #1;
        checkOutput("t3_last_rv", 64'(resp_valid), 64'(2'b01));
        @(negedge clk);
        #1;
        checkOutput("t3_next_rdy", 64'(req_ready), 64'(2'b10));
        checkOutput("t3_next_rv",  64'(resp_valid), 64'd0);
        resp_ready = 2'b11;
        serve("t3b", 2'b10, 64'd7, 1'b0, 1'b0);

        // Illegal opcode, then a legal one clears the error
        applyStimulus(1, 64'h1234, 64'h5678, 4'd3);
        serve("t4a", 2'b10, 64'd0, 1'b0, 1'b1);
        applyStimulus(0, 64'h0F, 64'hF0, 4'd1);
        serve("t4b", 2'b01, 64'hFF, 1'b0, 1'b0);

        // NOR of zeros and wrap-around subtraction
        applyStimulus(0, 64'd0, 64'd0, 4'd12);
        serve("t5a", 2'b01, ALL_ONES, 1'b0, 1'b0);
        applyStimulus(1, 64'd0, 64'd1, 4'd6);
        serve("t5b", 2'b10, ALL_ONES, 1'b0, 1'b0);

        // Move the pointer to requester 1, then abort a transaction with reset
        applyStimulus(0, 64'd3, 64'd1, 4'd0);
        serve("t6pre", 2'b01, 64'd1, 1'b0, 1'b0);
        applyStimulus(0, 64'd9, 64'd9, 4'd2);
        #1;
        checkOutput("t6_grant", 64'(req_ready), 64'(2'b01));
        @(negedge clk);
        req_valid = '0;
        doReset("t6");
        #1;
        checkOutput("t6_after_rv", 64'(resp_valid), 64'd0);
        checkOutput("t6_after_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("t6_after_rv2", 64'(resp_valid), 64'd0);
        applyStimulus(0, 64'd2, 64'd3, 4'd2);
        applyStimulus(1, 64'd1, 64'd1, 4'd2);
        serve("t6b", 2'b01, 64'd5, 1'b0, 1'b0);
        serve("t6c", 2'b10, 64'd2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

endmodule
